// File: rtl/mux_2to1.sv
// mux_2to1: two-input word multiplexer for datapath source selection
// (ALU operand, PC-next, write-back).
//
// Ports:
//   clk        rising-edge clock, used only by the registered outputs
//   reset      asynchronous active-high reset, clears the registered outputs only
//   dataA      word selected when select = 0
//   dataB      word selected when select = 1
//   select     source select
//   muxOut     combinational result
//   muxOutReg  muxOut registered on clk
//   selectReg  select registered on clk
module mux_2to1 #(
    parameter int unsigned SIZE = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] dataA,
    input  logic [SIZE-1:0] dataB,
    input  logic            select,
    output logic [SIZE-1:0] muxOut,
    output logic [SIZE-1:0] muxOutReg,
    output logic            selectReg
);

    // Plain ?: so an unknown select yields the bits where both words agree.
    assign muxOut = select ? dataB : dataA;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            muxOutReg <= '0;
            selectReg <= 1'b0;
        end else begin
            muxOutReg <= muxOut;
            selectReg <= select;
        end
    end

endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: directed self-checking bench for mux_2to1.
// Three instances: SIZE=4 clocked, SIZE=4 with clk/reset tied off, SIZE=32.
module tb_mux_2to1;

    logic       clk;
    logic       reset;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       sel4;
    logic [3:0] out4;
    logic [3:0] out4_reg;
    logic       sel4_reg;

    logic [3:0] a_t;
    logic [3:0] b_t;
    logic       sel_t;
    logic [3:0] out_t;
    logic [3:0] out_t_reg;
    logic       sel_t_reg;

    logic [31:0] a32;
    logic [31:0] b32;
    logic        sel32;
    logic [31:0] out32;
    logic [31:0] out32_reg;
    logic        sel32_reg;

    int checks = 0;
    int fails  = 0;

    mux_2to1 #(.SIZE(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .dataA     (a4),
        .dataB     (b4),
        .select    (sel4),
        .muxOut    (out4),
        .muxOutReg (out4_reg),
        .selectReg (sel4_reg)
    );

    mux_2to1 #(.SIZE(4)) u_tied (
        .clk       (1'b0),
        .reset     (1'b0),
        .dataA     (a_t),
        .dataB     (b_t),
        .select    (sel_t),
        .muxOut    (out_t),
        .muxOutReg (out_t_reg),
        .selectReg (sel_t_reg)
    );

    mux_2to1 #(.SIZE(32)) u_dut32 (
        .clk       (clk),
        .reset     (reset),
        .dataA     (a32),
        .dataB     (b32),
        .select    (sel32),
        .muxOut    (out32),
        .muxOutReg (out32_reg),
        .selectReg (sel32_reg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        a_t = '0; b_t = '0; sel_t = 1'b0;
        a32 = '0; b32 = '0; sel32 = 1'b0;

        // Combinational selection, SIZE=4.
        a4 = 4'b1010; b4 = 4'b0101; sel4 = 1'b0;
        #1 check("comb_1010_sel0", 32'(out4), 32'h0000000a);
        sel4 = 1'b1;
        #1 check("comb_0101_sel1", 32'(out4), 32'h00000005);
        a4 = 4'b1111; b4 = 4'b0000; sel4 = 1'b0;
        #1 check("comb_1111_sel0", 32'(out4), 32'h0000000f);
        sel4 = 1'b1;
        #1 check("comb_0000_sel1", 32'(out4), 32'h00000000);

        // Tied-off clock and reset.
        a_t = 4'b0011; b_t = 4'b1100; sel_t = 1'b0;
        #1 check("tied_sel0", 32'(out_t), 32'h00000003);
        sel_t = 1'b1;
        #1 check("tied_sel1", 32'(out_t), 32'h0000000c);

        // Full-width words.
        a32 = 32'hffffffff; b32 = 32'h00000001; sel32 = 1'b0;
        #1 check("w32_sel0", out32, 32'hffffffff);
        sel32 = 1'b1;
        #1 check("w32_sel1", out32, 32'h00000001);

        // Asynchronous reset between edges.
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check("rst_async_reg", 32'(out4_reg), 32'h00000000);
        check("rst_async_sel", 32'(sel4_reg), 32'h00000000);
        check("rst_async_w32", out32_reg, 32'h00000000);
        check("rst_comb_kept", 32'(out4), 32'h00000000);

        // First capture after release.
        @(negedge clk);
        reset = 1'b0;
        a4 = 4'b1010; sel4 = 1'b0;
        @(posedge clk);
        #1 check("cap1_reg", 32'(out4_reg), 32'h0000000a);
        check("cap1_sel", 32'(sel4_reg), 32'h00000000);

        // One-cycle latency: old value holds until the edge.
        @(negedge clk);
        sel4 = 1'b1; b4 = 4'b0101;
        #1 check("pre_edge_reg", 32'(out4_reg), 32'h0000000a);
        check("pre_edge_sel", 32'(sel4_reg), 32'h00000000);
        check("comb_after_switch", 32'(out4), 32'h00000005);
        @(posedge clk);
        #1 check("cap2_reg", 32'(out4_reg), 32'h00000005);
        check("cap2_sel", 32'(sel4_reg), 32'h00000001);
        check("cap2_w32", out32_reg, 32'h00000001);

        // Reset mid-operation clears immediately, comb path keeps tracking.
        @(negedge clk);
        reset = 1'b1;
        #1 check("rst_mid_reg", 32'(out4_reg), 32'h00000000);
        check("rst_mid_sel", 32'(sel4_reg), 32'h00000000);
        check("rst_mid_comb", 32'(out4), 32'h00000005);

        // Held reset blocks capture across an edge.
        @(posedge clk);
        #1 check("rst_hold_reg", 32'(out4_reg), 32'h00000000);
        check("rst_hold_sel", 32'(sel4_reg), 32'h00000000);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
